// File: rtl/norm_divider.sv
// Per-vector L1 normalizer: accumulates lane magnitudes, exchanges the sum with a peer core,
// then divides each lane by the joint total (Q.8). Optional rounding step via NORM_ROUND_EN.
module norm_divider #(
  parameter int unsigned col     = 8,
  parameter int unsigned bw_psum = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col*bw_psum-1:0]   psum_in,
  input  logic                     psum_valid,
  output logic                     psum_ready,
  output logic [bw_psum+3:0]       sum_out,
  output logic                     sum_out_valid,
  input  logic [bw_psum+3:0]       sum_in,
  input  logic                     sum_in_valid,
  output logic                     sum_in_ack,
  output logic [col*bw_psum-1:0]   norm_out,
  output logic                     norm_valid
);

  localparam int unsigned SW = bw_psum + 4;
  localparam int unsigned RW = bw_psum + 5;
  localparam int unsigned LW = (col > 1) ? $clog2(col) : 1;
`ifdef NORM_ROUND_EN
  localparam int unsigned NSTEP = 10;
`else
  localparam int unsigned NSTEP = 9;
`endif

  typedef enum logic [2:0] {IDLE, ACCUM, WAIT_EXT, DIVIDE, DONE} state_t;

  state_t state, next_state;

  logic signed [bw_psum-1:0] lane_q [col];
  logic        [bw_psum-1:0] res_q  [col];
  logic [SW-1:0] acc_q;
  logic [SW-1:0] total_q;
  logic [RW-1:0] rem_q;
  logic [8:0]    quo_q;
  logic [LW-1:0] idx_q;
  logic [3:0]    step_q;

  logic signed [bw_psum-1:0] cur_lane;
  logic [bw_psum-1:0]        cur_mag;
  logic                      last_lane;
  logic                      last_step;
  logic                      capture;
  logic [SW-1:0]             acc_nx;
  logic [SW-1:0]             total_c;
  logic [RW-1:0]             rem_sh;
  logic [RW-1:0]             rem_nx;
  logic                      ge;
  logic [8:0]                quo_base;
  logic [8:0]                quo_nx;
  logic [bw_psum-1:0]        q_ext;
  logic [bw_psum-1:0]        lane_res;

  // Shared lane / division-step datapath
  always_comb begin
    cur_lane  = lane_q[idx_q];
    cur_mag   = cur_lane[bw_psum-1] ? -cur_lane : cur_lane;
    last_lane = (idx_q == LW'(col - 1));
    last_step = (step_q == 4'(NSTEP - 1));
    capture   = psum_valid && psum_ready;
    acc_nx    = acc_q + SW'(cur_mag);
    total_c   = sum_out + sum_in;
    rem_sh    = (step_q == 4'd0) ? RW'(cur_mag) : {rem_q[RW-2:0], 1'b0};
    ge        = (rem_sh >= RW'(total_q));
    rem_nx    = ge ? (rem_sh - RW'(total_q)) : rem_sh;
    quo_base  = (step_q == 4'd0) ? 9'd0 : quo_q;
    quo_nx    = quo_base;
`ifdef NORM_ROUND_EN
    if (step_q == 4'd9) begin
      if (ge && (quo_base != 9'd256)) quo_nx = quo_base + 9'd1;
    end else if (ge) begin
      quo_nx = quo_base | (9'd1 << (4'd8 - step_q));
    end
`else
    if (ge) quo_nx = quo_base | (9'd1 << (4'd8 - step_q));
`endif
    q_ext    = bw_psum'(quo_nx);
    lane_res = cur_lane[bw_psum-1] ? -q_ext : q_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (capture) next_state = ACCUM;
      ACCUM:    if (last_lane) next_state = WAIT_EXT;
      WAIT_EXT: if (sum_in_valid) next_state = (total_c == '0) ? DONE : DIVIDE;
      DIVIDE:   if (last_step && last_lane) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      psum_ready    <= 1'b0;
      sum_out       <= '0;
      sum_out_valid <= 1'b0;
      sum_in_ack    <= 1'b0;
      norm_out      <= '0;
      norm_valid    <= 1'b0;
      acc_q         <= '0;
      total_q       <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      idx_q         <= '0;
      step_q        <= '0;
      for (int i = 0; i < int'(col); i++) begin
        lane_q[i] <= '0;
        res_q[i]  <= '0;
      end
    end else begin
      psum_ready    <= (next_state == IDLE);
      sum_out_valid <= (next_state == WAIT_EXT);
      sum_in_ack    <= 1'b0;
      norm_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            for (int i = 0; i < int'(col); i++) lane_q[i] <= psum_in[i*bw_psum +: bw_psum];
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        ACCUM: begin
          acc_q <= acc_nx;
          if (last_lane) begin
            sum_out <= acc_nx;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + LW'(1);
          end
        end
        WAIT_EXT: begin
          if (sum_in_valid) begin
            total_q    <= total_c;
            sum_in_ack <= 1'b1;
            idx_q      <= '0;
            step_q     <= '0;
            for (int i = 0; i < int'(col); i++) res_q[i] <= '0;
          end
        end
        DIVIDE: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          if (last_step) begin
            res_q[idx_q] <= lane_res;
            step_q       <= '0;
            idx_q        <= last_lane ? '0 : idx_q + LW'(1);
          end else begin
            step_q <= step_q + 4'd1;
          end
        end
        DONE: begin
          for (int i = 0; i < int'(col); i++) norm_out[i*bw_psum +: bw_psum] <= res_q[i];
          norm_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_divider.sv
// Scoreboard bench for norm_divider: expected sums/lanes queued at stimulus, checked on output.
module tb_norm_divider;

  localparam int unsigned COL = 8;
  localparam int unsigned BW  = 19;
`ifdef NORM_ROUND_EN
  localparam int LAT = COL + 1 + 10*COL + 1;
`else
  localparam int LAT = COL + 1 + 9*COL + 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [COL*BW-1:0] psum_in;
  logic              psum_valid;
  logic              psum_ready;
  logic [BW+3:0]     sum_out;
  logic              sum_out_valid;
  logic [BW+3:0]     sum_in;
  logic              sum_in_valid;
  logic              sum_in_ack;
  logic [COL*BW-1:0] norm_out;
  logic              norm_valid;

  norm_divider #(.col(COL), .bw_psum(BW)) dut (
    .clk(clk), .reset(reset), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .sum_out(sum_out), .sum_out_valid(sum_out_valid),
    .sum_in(sum_in), .sum_in_valid(sum_in_valid), .sum_in_ack(sum_in_ack),
    .norm_out(norm_out), .norm_valid(norm_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int norm_cnt = 0;
  longint exp_sum_q[$];
  longint exp_norm_q[$];

  always @(posedge clk) begin
    cyc++;
    if (sum_in_ack) ack_cnt++;
    if (norm_valid) norm_cnt++;
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model_lane(input int v, input longint total);
    longint m, q;
    m = (v < 0) ? -longint'(v) : longint'(v);
    if (total == 0) return 0;
`ifdef NORM_ROUND_EN
    q = (m * 512 + total) / (2 * total);
    if (q > 256) q = 256;
`else
    q = (m * 256) / total;
`endif
    return (v < 0) ? -q : q;
  endfunction

  task automatic run_vector(input int lanes[COL], input int sin, input int hold,
                            input bit pre_valid, input bit poke, input int exp_lat);
    longint s, total, prev;
    int cap, w, ab, nb;
    s = 0;
    for (int i = 0; i < int'(COL); i++) s += (lanes[i] < 0) ? -longint'(lanes[i]) : longint'(lanes[i]);
    total = s + sin;
    exp_sum_q.push_back(s);
    for (int i = 0; i < int'(COL); i++) exp_norm_q.push_back(model_lane(lanes[i], total));
    ab = ack_cnt;
    nb = norm_cnt;

    @(negedge clk);
    check_val("ready_idle", longint'(psum_ready), 1);
    for (int i = 0; i < int'(COL); i++) psum_in[i*BW +: BW] = BW'(lanes[i]);
    sum_in       = (BW+4)'(sin);
    sum_in_valid = pre_valid;
    psum_valid   = 1'b1;
    @(negedge clk);
    psum_valid = 1'b0;
    cap = cyc;

    w = 0;
    while (!sum_out_valid && w < 200) begin @(negedge clk); w++; end
    check_val("sum_out_valid", longint'(sum_out_valid), 1);
    check_val("sum_out", longint'(sum_out), exp_sum_q.pop_front());

    if (!pre_valid) begin
      prev = longint'(sum_out);
      repeat (hold) @(negedge clk);
      check_val("wait_ext_valid", longint'(sum_out_valid), 1);
      check_val("sum_out_stable", longint'(sum_out), prev);
      check_val("no_early_ack", longint'(ack_cnt - ab), 0);
      sum_in_valid = 1'b1;
    end

    w = 0;
    while (!sum_in_ack && w < 200) begin @(negedge clk); w++; end
    check_val("ack_seen", longint'(sum_in_ack), 1);
    sum_in_valid = 1'b0;

    if (poke) begin
      repeat (4) begin
        @(negedge clk);
        check_val("ready_busy", longint'(psum_ready), 0);
        psum_valid = 1'b1;
        @(negedge clk);
        psum_valid = 1'b0;
      end
    end

    w = 0;
    while (!norm_valid && w < 300) begin @(negedge clk); w++; end
    check_val("norm_valid", longint'(norm_valid), 1);
    if (exp_lat > 0) check_val("latency", longint'(cyc - cap), longint'(exp_lat));
    for (int i = 0; i < int'(COL); i++)
      check_val($sformatf("lane%0d", i), longint'($signed(norm_out[i*BW +: BW])), exp_norm_q.pop_front());

    repeat (3) @(negedge clk);
    check_val("ack_pulses", longint'(ack_cnt - ab), 1);
    check_val("norm_pulses", longint'(norm_cnt - nb), 1);
    check_val("norm_hold", longint'($signed(norm_out[0 +: BW])), model_lane(lanes[0], total));
  endtask

  initial begin
    int v[COL];
    int nb;
    reset = 1'b1; psum_in = '0; psum_valid = 1'b0; sum_in = '0; sum_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", longint'(psum_ready), 0);
    check_val("rst_sum_out", longint'(sum_out), 0);
    check_val("rst_norm_out", longint'(norm_out != '0), 0);
    check_val("rst_norm_valid", longint'(norm_valid), 0);
    reset = 1'b0;
    @(negedge clk);
    check_val("ready_after_rst", longint'(psum_ready), 1);

    v = '{100, -50, 0, 0, 0, 0, 0, 0};
    run_vector(v, 50, 0, 1'b1, 1'b0, LAT);

    v = '{2, 0, 0, 0, 0, 0, 0, 0};
    run_vector(v, 1, 0, 1'b1, 1'b0, LAT);

    v = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_vector(v, 0, 0, 1'b1, 1'b0, int'(COL) + 2);

    v = '{1234, -777, 5, 0, -262144, 262143, 99, -1};
    run_vector(v, 4321, 20, 1'b0, 1'b0, 0);

    v = '{-262144, 0, 0, 0, 0, 0, 0, 0};
    run_vector(v, 0, 0, 1'b1, 1'b1, LAT);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < int'(COL); i++) v[i] = int'($urandom_range(0, 524286)) - 262143;
      run_vector(v, int'($urandom_range(0, 1000000)), int'($urandom_range(0, 5)), 1'b0, 1'b0, 0);
    end

    // Abort a vector in the middle of the division phase
    v = '{300, -200, 100, 0, 0, 0, 0, 0};
    @(negedge clk);
    for (int i = 0; i < int'(COL); i++) psum_in[i*BW +: BW] = BW'(v[i]);
    sum_in = (BW+4)'(10);
    sum_in_valid = 1'b1;
    psum_valid = 1'b1;
    @(negedge clk);
    psum_valid = 1'b0;
    repeat (12) @(negedge clk);
    sum_in_valid = 1'b0;
    repeat (18) @(negedge clk);
    nb = norm_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_ready", longint'(psum_ready), 0);
    check_val("abort_sum_out", longint'(sum_out), 0);
    check_val("abort_sum_out_valid", longint'(sum_out_valid), 0);
    check_val("abort_norm_out", longint'(norm_out != '0), 0);
    check_val("abort_norm_valid", longint'(norm_valid), 0);
    repeat (100) @(negedge clk);
    check_val("abort_no_norm", longint'(norm_cnt - nb), 0);
    check_val("abort_idle", longint'(psum_ready), 1);

    v = '{100, -50, 0, 0, 0, 0, 0, 0};
    run_vector(v, 50, 0, 1'b1, 1'b0, LAT);

    check_val("sb_empty", longint'(exp_sum_q.size() + exp_norm_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
